ctrl_muldiv_seq: RTL and testbench
==================================

# ctrl_muldiv_seq

Multi-cycle multiply/divide sequencer for the 16-bit pipeline. When stage one decodes a MUL or DIV function, it issues `start`. This block then holds the pipeline with `stall` while it iterates a shift-add multiplier or a restoring divider over `WIDTH` cycles. It returns a 32-bit result in the same {hi, lo} packing as `aluout`, together with the `div0` and `overflow` flags consumed by `control_main`.

## Interface
- `WIDTH`, default 16: operand width. Sets the iteration count and the result width of `2*WIDTH`.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: request a new operation. Sampled only in IDLE.
- `op`, input, 1: operation select. 0 = MUL, 1 = DIV. Sampled with `start`.
- `a`, input, WIDTH: multiplicand or dividend. Sampled with `start`.
- `b`, input, WIDTH: multiplier or divisor. Sampled with `start`.
- `halt_sys`, input, 1: freeze. All state and the counter hold while high.
- `flush`, input, 1: abort the current operation and return to IDLE.
- `stall`, output, 1: combinational hold request to the pipeline.
- `busy`, output, 1: registered. High in every state except IDLE.
- `done`, output, 1: registered one-cycle pulse. Result and flags are valid.
- `result`, output, 2*WIDTH: registered.
  - MUL: {product hi, product lo}.
  - DIV: {remainder, quotient}.
- `div0`, output, 1: registered. Divide by zero on the last completed DIV.
- `overflow`, output, 1: registered. Overflow on the last completed operation.

## Operation
- States: IDLE, CALC, FIX, DONE. FIX exists only with `MULDIV_SIGNED_EN`.
- Reset values:
  - state = IDLE.
  - count, accumulator, `result`, `done`, `busy`, `div0`, `overflow` all 0.
- IDLE:
  - `start`=1 latches `op`, `a` and `b`, and clears count to 0.
  - If `op`=DIV and `b`=0, go to DONE directly.
  - Otherwise go to CALC.
- CALC runs one iteration per cycle.
  - MUL: add `b` to the upper half when the multiplier LSB is 1, then shift right the 2W accumulator (W+1-bit add, carry kept).
  - DIV: restoring divide. Shift {rem, quo} left by 1 and trial-subtract the divisor. If the subtraction does not go negative, keep the difference and set quotient LSB to 1.
  - On count = WIDTH-1, go to FIX if it is compiled in, otherwise to DONE.
- FIX applies sign correction (see Configuration). Always exits to DONE after one cycle.
- DONE:
  - `done`=1 and `result`/flags are updated on entry.
  - Unconditionally returns to IDLE next cycle.
  - `start` is not accepted in DONE.
- Divide by zero: `result` = {`a`, all ones}, `div0`=1, `overflow`=0.
- MUL `overflow`:
  - Unsigned: product hi ≠ 0.
  - Signed: hi is not the sign-extension of lo.
- DIV `overflow` is 0 unsigned. Signed, it is set only for most-negative / -1.
- `result`, `div0` and `overflow` hold their values until the next DONE.
- `flush` takes priority over everything but `rst`:
  - Any state goes to IDLE next cycle.
  - No `done` pulse.
  - `result` and flags are unchanged.
- `halt_sys`=1 and `flush`=0: no state change and no counter change, and `done` stays low. A DONE state entered before the halt keeps its pulse until the halt releases, then its `done` deasserts.
- `rst` mid-operation returns to the reset values immediately.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- `stall` = (IDLE & `start` & ~`flush`) | (state ∈ {CALC, FIX}). Stage one is therefore held in cycle 0.
- `stall` is low in DONE, so the stage one flop captures `result` in that cycle.
- Latency to the `done` cycle:
  - Unsigned: WIDTH+1, i.e. cycle 17 for WIDTH=16.
  - Signed build: WIDTH+2, i.e. cycle 18.
  - Divide by zero: cycle 1.
- Each halted cycle adds exactly one cycle to the latency.
- Back-to-back operations: the earliest next `start` is accepted the cycle after DONE.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - Operands are two's complement.
  - IDLE latches the magnitudes and records sign_q = sa^sb and sign_r = sa.
  - FIX negates the quotient/product per sign_q and the remainder per sign_r.
  - Most-negative / -1 gives quotient = most-negative, remainder = 0, `overflow`=1.
- `MULDIV_SIGNED_EN` undefined:
  - Unsigned only.
  - The FIX state, its sign registers and its logic are absent.
  - CALC exits directly to DONE.

## Test plan
- Unsigned MUL with `a`=0xFFFF, `b`=0xFFFF:
  - `done` at cycle 17 with `result`=0xFFFE0001 and `overflow`=1.
  - `stall` high in cycles 0–16 and low in cycle 17.
- Unsigned DIV with `a`=100, `b`=7:
  - `result`=0x0002000E, `div0`=0, `done` at cycle 17.
- DIV with `a`=0x1234, `b`=0:
  - `done` at cycle 1 with `result`=0x1234FFFF, `div0`=1.
  - `stall` high only in cycle 0.
- Signed build:
  - -7/2 (0xFFF9/0x0002) gives `result`=0xFFFFFFFD (rem -1, quo -3), `done` at cycle 18.
  - 0x8000/0xFFFF gives `result`=0x00008000 with `overflow`=1.
- `halt_sys` high in cycles 5–7 of a MUL of 3×4: `done` at cycle 20 with `result`=0x0000000C.
- `flush` at cycle 8 of a DIV: IDLE at cycle 9, no `done`, prior `result` retained.
- `rst` mid-CALC: all outputs 0 immediately.

Source files
------------

// File: rtl/ctrl_muldiv_seq.sv
// Multi-cycle shift-add multiplier / restoring divider that stalls the pipeline.
// Define MULDIV_SIGNED_EN for two's-complement operands with a FIX sign pass.
module ctrl_muldiv_seq #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               halt_sys,
   input  logic               flush,
   output logic               stall,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               div0,
   output logic               overflow
);

   localparam int W  = WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST   = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  ONE_C  = CW'(1);
   localparam logic [W-1:0]   ONE_W  = W'(1);
   localparam logic [2*W-1:0] ONE_2W = (2*W)'(1);

`ifdef MULDIV_SIGNED_EN
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

   state_t         state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [W-1:0]   b_q, b_d;
   logic           op_q, op_d;
   logic [2*W-1:0] result_q, result_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;
   logic           div0_q, div0_d;
   logic           ovf_q, ovf_d;

   logic [W-1:0]   a_mag, b_mag;
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_nxt;
   logic [W:0]     rem_sh;
   logic [W+1:0]   div_diff;
   logic [2*W-1:0] div_nxt;
   logic [2*W-1:0] acc_nxt;

`ifdef MULDIV_SIGNED_EN
   logic           sign_q_q, sign_q_d;
   logic           sign_r_q, sign_r_d;
   logic [2*W-1:0] prod_f;
   logic [W-1:0]   hi_f, lo_f;
   logic           fix_ovf;

   assign a_mag = a[W-1] ? (~a + ONE_W) : a;
   assign b_mag = b[W-1] ? (~b + ONE_W) : b;

   // Quotient/product take sign_q, remainder takes the dividend sign.
   always_comb begin
      prod_f  = sign_q_q ? (~acc_q + ONE_2W) : acc_q;
      hi_f    = prod_f[2*W-1:W];
      lo_f    = prod_f[W-1:0];
      fix_ovf = (hi_f != {W{lo_f[W-1]}});
      if (op_q) begin
         hi_f    = sign_r_q ? (~acc_q[2*W-1:W] + ONE_W) : acc_q[2*W-1:W];
         lo_f    = sign_q_q ? (~acc_q[W-1:0] + ONE_W) : acc_q[W-1:0];
         fix_ovf = ~sign_q_q & acc_q[W-1];
      end
   end
`else
   assign a_mag = a;
   assign b_mag = b;
`endif

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? b_q : '0)};
      mul_nxt  = {mul_sum, acc_q[W-1:1]};
      rem_sh   = acc_q[2*W-1:W-1];
      div_diff = {1'b0, rem_sh} - {2'b00, b_q};
      div_nxt  = div_diff[W+1] ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                               : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
      acc_nxt  = op_q ? div_nxt : mul_nxt;
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      acc_d    = acc_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      done_d   = 1'b0;
      div0_d   = div0_q;
      ovf_d    = ovf_q;
`ifdef MULDIV_SIGNED_EN
      sign_q_d = sign_q_q;
      sign_r_d = sign_r_q;
`endif
      if (flush) begin
         state_d = IDLE;
      end else if (halt_sys) begin
         done_d = done_q;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  op_d    = op;
                  count_d = '0;
                  b_d     = b_mag;
                  acc_d   = {{W{1'b0}}, a_mag};
`ifdef MULDIV_SIGNED_EN
                  sign_q_d = a[W-1] ^ b[W-1];
                  sign_r_d = a[W-1];
`endif
                  if (op && (b == '0)) begin
                     state_d  = DONE;
                     done_d   = 1'b1;
                     result_d = {a, {W{1'b1}}};
                     div0_d   = 1'b1;
                     ovf_d    = 1'b0;
                  end else begin
                     state_d = CALC;
                  end
               end
            end
            CALC: begin
               count_d = count_q + ONE_C;
               acc_d   = acc_nxt;
               if (count_q == LAST) begin
`ifdef MULDIV_SIGNED_EN
                  state_d = FIX;
`else
                  state_d  = DONE;
                  done_d   = 1'b1;
                  result_d = acc_nxt;
                  div0_d   = 1'b0;
                  ovf_d    = ~op_q & (acc_nxt[2*W-1:W] != '0);
`endif
               end
            end
`ifdef MULDIV_SIGNED_EN
            FIX: begin
               state_d  = DONE;
               done_d   = 1'b1;
               result_d = {hi_f, lo_f};
               div0_d   = 1'b0;
               ovf_d    = fix_ovf;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         op_q     <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         div0_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         sign_q_q <= 1'b0;
         sign_r_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         div0_q   <= div0_d;
         ovf_q    <= ovf_d;
`ifdef MULDIV_SIGNED_EN
         sign_q_q <= sign_q_d;
         sign_r_q <= sign_r_d;
`endif
      end
   end

   // Stall in the issue cycle so stage one holds the operands.
   assign stall = ((state_q == IDLE) & start & ~flush)
                | (state_q == CALC)
`ifdef MULDIV_SIGNED_EN
                | (state_q == FIX)
`endif
                ;

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign div0     = div0_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_ctrl_muldiv_seq.sv
// Directed bench for ctrl_muldiv_seq: latency, stall window, flags, halt, flush, reset.
// Signed expectations apply when MULDIV_SIGNED_EN is defined.
module tb_ctrl_muldiv_seq;

`ifdef MULDIV_SIGNED_EN
   localparam int LAT = 18;
   localparam logic [31:0] FF_PROD = 32'h0000_0001;
   localparam logic        FF_OVF  = 1'b0;
`else
   localparam int LAT = 17;
   localparam logic [31:0] FF_PROD = 32'hFFFE_0001;
   localparam logic        FF_OVF  = 1'b1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        halt_sys = 1'b0;
   logic        flush = 1'b0;
   logic        stall, busy, done, div0, overflow;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   int dcyc, scnt;
   logic s_done, b_done;
   bit seen;

   ctrl_muldiv_seq #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .halt_sys(halt_sys), .flush(flush), .stall(stall), .busy(busy),
      .done(done), .result(result), .div0(div0), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the done cycle.
   task automatic issue(input logic o, input logic [15:0] xa,
                        input logic [15:0] xb, input int hf, input int ht);
      int cyc;
      op = o; a = xa; b = xb; start = 1'b1;
      cyc = 0; dcyc = -1; scnt = 0; s_done = 1'bx; b_done = 1'bx;
      while (cyc < 60 && dcyc < 0) begin
         halt_sys = (cyc >= hf) && (cyc <= ht);
         #1;
         if (stall) scnt++;
         if (done) begin
            dcyc = cyc; s_done = stall; b_done = busy;
         end
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end
      halt_sys = 1'b0;
      chk("timeout", 32'(dcyc >= 0), 32'd1);
   endtask

   initial begin
      #12;
      chk("rst_result", result, 32'h0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_div0", 32'(div0), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      issue(1'b0, 16'hFFFF, 16'hFFFF, -1, -1);
      chk("mulff_cyc", 32'(dcyc), 32'(LAT));
      chk("mulff_res", result, FF_PROD);
      chk("mulff_ovf", 32'(overflow), 32'(FF_OVF));
      chk("mulff_stall_cnt", 32'(scnt), 32'(LAT));
      chk("mulff_stall_done", 32'(s_done), 32'd0);
      chk("mulff_busy_done", 32'(b_done), 32'd1);
      #1;
      chk("mulff_pulse", 32'(done), 32'd0);
      chk("mulff_idle", 32'(busy), 32'd0);

      @(negedge clk);
      issue(1'b1, 16'd100, 16'd7, -1, -1);
      chk("div100_cyc", 32'(dcyc), 32'(LAT));
      chk("div100_res", result, 32'h0002_000E);
      chk("div100_div0", 32'(div0), 32'd0);
      chk("div100_ovf", 32'(overflow), 32'd0);

      issue(1'b1, 16'h1234, 16'h0000, -1, -1);
      chk("div0_cyc", 32'(dcyc), 32'd1);
      chk("div0_res", result, 32'h1234_FFFF);
      chk("div0_flag", 32'(div0), 32'd1);
      chk("div0_ovf", 32'(overflow), 32'd0);
      chk("div0_stall_cnt", 32'(scnt), 32'd1);

      issue(1'b0, 16'd3, 16'd4, 5, 7);
      chk("halt_cyc", 32'(dcyc), 32'(LAT + 3));
      chk("halt_res", result, 32'h0000_000C);
      chk("halt_div0", 32'(div0), 32'd0);
      chk("halt_ovf", 32'(overflow), 32'd0);

      // Flush at cycle 8 of a divide; prior result must survive.
      op = 1'b1; a = 16'd100; b = 16'd7; start = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 9; c++) begin
         if (c == 8) flush = 1'b1;
         #1;
         if (done) seen = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      flush = 1'b0;
      #1;
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_stall", 32'(stall), 32'd0);
      chk("flush_res", result, 32'h0000_000C);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      chk("flush_no_done", 32'(seen), 32'd0);
      chk("flush_res_hold", result, 32'h0000_000C);
      @(negedge clk);

`ifdef MULDIV_SIGNED_EN
      issue(1'b1, 16'hFFF9, 16'h0002, -1, -1);
      chk("sdiv_cyc", 32'(dcyc), 32'd18);
      chk("sdiv_res", result, 32'hFFFF_FFFD);
      chk("sdiv_ovf", 32'(overflow), 32'd0);
      issue(1'b1, 16'h8000, 16'hFFFF, -1, -1);
      chk("sdiv_min_res", result, 32'h0000_8000);
      chk("sdiv_min_ovf", 32'(overflow), 32'd1);
      issue(1'b0, 16'hFFFD, 16'h0004, -1, -1);
      chk("smul_res", result, 32'hFFFF_FFF4);
      chk("smul_ovf", 32'(overflow), 32'd0);
`endif

      // Asynchronous reset in the middle of CALC.
      issue(1'b1, 16'h0001, 16'h0000, -1, -1);
      chk("pre_rst_div0", 32'(div0), 32'd1);
      op = 1'b0; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_result", result, 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_div0", 32'(div0), 32'd0);
      chk("mid_rst_stall", 32'(stall), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(1'b0, 16'd3, 16'd4, -1, -1);
      chk("post_rst_res", result, 32'h0000_000C);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
